// File: rtl/alu_issue.sv
// alu_issue: operand issue stage in front of the registered 32-bit add/sub alu.
// Buffers requests in a DEPTH-entry FIFO, feeds the ALU one op at a time,
// captures its one-cycle-late result and presents it over valid/ready.
// Optional feature macro: ALU_ISSUE_COUNT_EN adds the op_count result counter.
module alu_issue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [1:0]  req_op,
  output logic [31:0] alu_in_a,
  output logic [31:0] alu_in_b,
  output logic [1:0]  opcode,
  input  logic [31:0] alu_res,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [1:0]  res_op,
`ifdef ALU_ISSUE_COUNT_EN
  output logic [31:0] op_count,
`endif
  output logic        busy
);

  localparam int unsigned DW  = 32;
  localparam int unsigned OPW = 2;
  localparam int unsigned PW  = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  typedef struct packed {
    logic [OPW-1:0] op;
    logic [DW-1:0]  a;
    logic [DW-1:0]  b;
  } req_t;

  req_t         mem [DEPTH];
  req_t         head;
  logic [PW:0]  wr_ptr;
  logic [PW:0]  rd_ptr;
  logic         empty;
  logic         full;
  logic         push_c;
  logic         pop_c;
  logic         load_res_c;
  logic         clr_res_c;
  logic [1:0]   state;
  logic [1:0]   state_nxt;

  // FIFO status; the extra pointer bit separates full from empty
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign head  = mem[rd_ptr[PW-1:0]];

  assign req_ready = !full && !rst;
  assign push_c    = req_valid && req_ready;
  assign busy      = (state != S_IDLE) || !empty;

  // Request storage; entries need no reset since pointers gate visibility
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr[PW-1:0]] <= '{op: req_op, a: req_a, b: req_b};
    end
  end

  // FIFO pointers, wrapping modulo DEPTH through the natural overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (pop_c)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and control decode
  always_comb begin
    state_nxt  = state;
    pop_c      = 1'b0;
    load_res_c = 1'b0;
    clr_res_c  = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop_c     = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        load_res_c = 1'b1;
        state_nxt  = S_DONE;
      end
      S_DONE: begin
        if (res_ready) begin
          clr_res_c = 1'b1;
          if (!empty) begin
            pop_c     = 1'b1;
            state_nxt = S_ISSUE;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ALU operand registers, loaded only on a pop and held otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_in_a <= '0;
      alu_in_b <= '0;
      opcode   <= '0;
      res_op   <= '0;
    end else if (pop_c) begin
      alu_in_a <= head.a;
      alu_in_b <= head.b;
      opcode   <= head.op;
      res_op   <= head.op;
    end
  end

  // Result capture from the ALU output register and downstream handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
    end else if (load_res_c) begin
      res_valid <= 1'b1;
      res_data  <= alu_res;
    end else if (clr_res_c) begin
      res_valid <= 1'b0;
    end
  end

`ifdef ALU_ISSUE_COUNT_EN
  // Completed-result counter, wrapping at 2^32
  always_ff @(posedge clk) begin
    if (rst)                         op_count <= '0;
    else if (res_valid && res_ready) op_count <= op_count + 32'd1;
  end
`endif

`ifndef SYNTHESIS
  // Operands stay put while the ALU samples and computes
  a_operands_stable: assert property (@(posedge clk) disable iff (rst)
    (state == S_WAIT) |-> ($stable(alu_in_a) && $stable(alu_in_b) && $stable(opcode)));

  // A presented result is held until the consumer takes it
  a_result_held: assert property (@(posedge clk) disable iff (rst)
    (state == S_DONE && $past(state) == S_DONE && !$past(res_ready))
      |-> (res_valid && $stable(res_data) && $stable(res_op)));
`endif

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: self-checking bench for alu_issue with a behavioural ALU and
// a queue-based scoreboard. Define ALU_ISSUE_COUNT_EN to cover op_count.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [1:0]  req_op;
  logic [31:0] alu_in_a;
  logic [31:0] alu_in_b;
  logic [1:0]  opcode;
  logic [31:0] alu_res = 32'd0;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [1:0]  res_op;
  logic        busy;
`ifdef ALU_ISSUE_COUNT_EN
  logic [31:0] op_count;
`endif

  logic rr_rand  = 1'b0;
  logic rr_fixed = 1'b1;
  logic rnd_bit  = 1'b1;
  assign res_ready = rr_rand ? rnd_bit : rr_fixed;

  int n_chk     = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int res_cnt   = 0;
  int cnt_model = 0;
  int res_cyc[$];
  logic [33:0] exp_q[$];
  logic [33:0] exp_e;

  alu_issue #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .alu_in_a  (alu_in_a),
    .alu_in_b  (alu_in_b),
    .opcode    (opcode),
    .alu_res   (alu_res),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_op    (res_op),
`ifdef ALU_ISSUE_COUNT_EN
    .op_count  (op_count),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Architectural ALU behaviour: add, sub, reserved codes give zero
  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      default: return 32'd0;
    endcase
  endfunction

  // Stand-in for the downstream alu: one registered cycle of latency
  always @(posedge clk) alu_res <= ref_alu(alu_in_a, alu_in_b, opcode);

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Cycle counter
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Random consumer readiness
  initial forever begin
    @(posedge clk);
    #1;
    rnd_bit = 1'($urandom_range(0, 1));
  end

  // Scoreboard: every accepted request must come back once, in order
  initial forever begin
    @(negedge clk);
    if (rst) begin
      exp_q.delete();
      cnt_model = 0;
    end else begin
      if (res_valid && res_ready) begin
        res_cnt++;
        cnt_model++;
        res_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          check_eq("res_unexpected", 64'(res_valid), 64'd0);
        end else begin
          exp_e = exp_q.pop_front();
          check_eq("res_data", 64'(res_data), 64'(exp_e[31:0]));
          check_eq("res_op", 64'(res_op), 64'(exp_e[33:32]));
        end
      end
      if (req_valid && req_ready) begin
        exp_q.push_back({req_op, ref_alu(req_a, req_b, req_op)});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    bit ok = 1'b0;
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    req_op    = op;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) step();
    else    check_eq("push_timeout", 64'(req_ready), 64'd1);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy && !res_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_eq("drain_timeout", {61'd0, exp_q.size() != 0, busy, res_valid}, 64'd0);
    step();
  endtask

  int  k;
  int  r0;
  bit  acc;
  bit  saw_valid;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_req_ready", 64'(req_ready), 64'd0);
    check_eq("rst_res_valid", 64'(res_valid), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_alu_in_a", 64'(alu_in_a), 64'd0);
    check_eq("rst_alu_in_b", 64'(alu_in_b), 64'd0);
    check_eq("rst_opcode", 64'(opcode), 64'd0);
    check_eq("rst_res_data", 64'(res_data), 64'd0);
    check_eq("rst_res_op", 64'(res_op), 64'd0);
`ifdef ALU_ISSUE_COUNT_EN
    check_eq("rst_op_count", 64'(op_count), 64'd0);
`endif
    step();
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_req_ready", 64'(req_ready), 64'd1);
    check_eq("post_rst_busy", 64'(busy), 64'd0);
    step();

    // Add latency: valid exactly three edges after accept
    rr_fixed = 1'b1;
    push(32'd5, 32'd3, 2'd0);
    for (int e = 0; e < 4; e++) begin
      @(negedge clk);
      check_eq($sformatf("add_valid_edge%0d", e), 64'(res_valid), 64'(e == 3));
    end
    check_eq("add_res_data", 64'(res_data), 64'd8);
    check_eq("add_res_op", 64'(res_op), 64'd0);
    step();
    drain();

    // Sub then reserved op, three cycles apart
    push(32'd10, 32'd3, 2'd1);
    push(32'd7, 32'd7, 2'd2);
    drain();
    check_eq("subres_gap", 64'(res_cyc[res_cyc.size()-1] - res_cyc[res_cyc.size()-2]), 64'd3);

    // Backpressure: DEPTH entries plus one held in DONE
    rr_fixed  = 1'b0;
    k         = 0;
    req_valid = 1'b1;
    req_a = 32'(100 + k); req_b = 32'(k); req_op = 2'(k & 1);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      acc = req_ready;
      step();
      if (acc) begin
        k++;
        req_a = 32'(100 + k); req_b = 32'(k); req_op = 2'(k & 1);
      end
    end
    req_valid = 1'b0;
    check_eq("bp_accepted", 64'(k), 64'd5);
    @(negedge clk);
    check_eq("bp_req_ready_full", 64'(req_ready), 64'd0);
    check_eq("bp_res_valid_held", 64'(res_valid), 64'd1);
    check_eq("bp_busy", 64'(busy), 64'd1);
    step();
    r0 = res_cnt;
    rr_fixed = 1'b1;
    @(negedge clk);
    check_eq("bp_ready_before_pop", 64'(req_ready), 64'd0);
    @(negedge clk);
    check_eq("bp_ready_after_pop", 64'(req_ready), 64'd1);
    step();
    drain();
    check_eq("bp_result_count", 64'(res_cnt - r0), 64'd5);

    // Pointer wrap-around with random consumer stalls
    r0 = res_cnt;
    rr_rand = 1'b1;
    for (int i = 0; i < 12; i++) push(32'(i), 32'd1, 2'd0);
    rr_rand = 1'b0;
    drain();
    check_eq("wrap_result_count", 64'(res_cnt - r0), 64'd12);

    // Random operands, opcodes and gaps
    r0 = res_cnt;
    rr_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) step();
      push($urandom, $urandom, 2'($urandom_range(0, 3)));
    end
    rr_rand = 1'b0;
    drain();
    check_eq("rand_result_count", 64'(res_cnt - r0), 64'd40);

    // Reset during WAIT with two entries queued
    push(32'd1, 32'd2, 2'd0);
    push(32'd3, 32'd4, 2'd1);
    push(32'd5, 32'd6, 2'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    r0 = res_cnt;
    saw_valid = 1'b0;
    @(negedge clk);
    check_eq("midrst_busy", 64'(busy), 64'd0);
    check_eq("midrst_req_ready", 64'(req_ready), 64'd1);
`ifdef ALU_ISSUE_COUNT_EN
    check_eq("midrst_op_count", 64'(op_count), 64'd0);
`endif
    for (int c = 0; c < 12; c++) begin
      saw_valid = saw_valid | res_valid;
      @(negedge clk);
    end
    check_eq("midrst_no_result", 64'(saw_valid), 64'd0);
    check_eq("midrst_result_count", 64'(res_cnt - r0), 64'd0);
    step();

    // Three completed ops, then counter cleared by reset
    push(32'd20, 32'd22, 2'd0);
    push(32'd9, 32'd10, 2'd1);
    push(32'd4, 32'd4, 2'd3);
    drain();
`ifdef ALU_ISSUE_COUNT_EN
    @(negedge clk);
    check_eq("count_three", 64'(op_count), 64'd3);
    check_eq("count_model", 64'(op_count), 64'(cnt_model));
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check_eq("count_cleared", 64'(op_count), 64'd0);
    step();
`endif
    check_eq("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global time bound
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
